// File: rtl/cp0_access_ctrl.sv
// cp0_access_ctrl: sequences MFC0/MTC0 requests and exception-entry
// read-modify-write traffic onto the single CP0 register-file port.
module cp0_access_ctrl #(
    parameter int unsigned EPC_RD    = 14,
    parameter int unsigned CAUSE_RD  = 13,
    parameter int unsigned STATUS_RD = 12,
    parameter logic [31:0] EXL_MASK  = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rt,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rt,
    input  logic        exc_req,
    input  logic [31:0] exc_epc,
    input  logic [4:0]  exc_code,
    input  logic        exc_bd,
    output logic        exc_done,
    output logic        cp0_we,
    output logic        cp0_re,
    output logic [4:0]  cp0_rd,
    output logic [2:0]  cp0_sel,
    output logic [31:0] cp0_din,
    input  logic [31:0] cp0_dout
);

    localparam int unsigned RD_W   = 5;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        EX_EPC     = 3'd2,
        EX_CAUSE   = 3'd3,
        EX_STAT_RD = 3'd4,
        EX_STAT_WR = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [RD_W-1:0]     rt_q, rt_d;
    logic [DATA_W-1:0]   epc_q, epc_d;
    logic [4:0]          code_q, code_d;
    logic                bd_q, bd_d;

    // State register plus latched MFC0 tag and exception fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rt_q    <= '0;
            epc_q   <= '0;
            code_q  <= '0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rt_q    <= rt_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
            bd_q    <= bd_d;
        end
    end

    // Next-state and port strobes; everything forced low while rst is high
    always_comb begin
        state_d    = state_q;
        rt_d       = rt_q;
        epc_d      = epc_q;
        code_d     = code_q;
        bd_d       = bd_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_rt    = '0;
        exc_done   = 1'b0;
        cp0_we     = 1'b0;
        cp0_re     = 1'b0;
        cp0_rd     = '0;
        cp0_sel    = '0;
        cp0_din    = '0;

        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    // Exception wins over a simultaneous request; no strobe this cycle
                    epc_d   = exc_epc;
                    code_d  = exc_code;
                    bd_d    = exc_bd;
                    state_d = EX_EPC;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        cp0_rd  = req_rd;
                        cp0_sel = req_sel;
                        if (req_write) begin
                            cp0_we  = 1'b1;
                            cp0_din = req_wdata;
                        end else begin
                            cp0_re  = 1'b1;
                            rt_d    = req_rt;
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                resp_valid = 1'b1;
                resp_rdata = cp0_dout;
                resp_rt    = rt_q;
                state_d    = IDLE;
            end
            EX_EPC: begin
                cp0_we  = 1'b1;
                cp0_rd  = RD_W'(EPC_RD);
                cp0_din = epc_q;
                state_d = EX_CAUSE;
            end
            EX_CAUSE: begin
                cp0_we  = 1'b1;
                cp0_rd  = RD_W'(CAUSE_RD);
                cp0_din = {bd_q, 24'b0, code_q, 2'b00};
                state_d = EX_STAT_RD;
            end
            EX_STAT_RD: begin
                cp0_re  = 1'b1;
                cp0_rd  = RD_W'(STATUS_RD);
                state_d = EX_STAT_WR;
            end
            EX_STAT_WR: begin
                cp0_we   = 1'b1;
                cp0_rd   = RD_W'(STATUS_RD);
                cp0_din  = cp0_dout | EXL_MASK;
                exc_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = '0;
            resp_rt    = '0;
            exc_done   = 1'b0;
            cp0_we     = 1'b0;
            cp0_re     = 1'b0;
            cp0_rd     = '0;
            cp0_sel    = SEL_W'(0);
            cp0_din    = '0;
        end
    end

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Scoreboard bench for cp0_access_ctrl with a one-cycle-latency register-file model.
module tb_cp0_access_ctrl;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_RESP = 2;
    localparam int K_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [4:0]  req_rd, req_rt;
    logic [2:0]  req_sel;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rt;
    logic        exc_req, exc_bd, exc_done;
    logic [31:0] exc_epc;
    logic [4:0]  exc_code;
    logic        cp0_we, cp0_re;
    logic [4:0]  cp0_rd;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_din, cp0_dout;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          npass = 0;
    int          ntotal = 0;
    int          cyc = 0;
    int          c;
    bit [31:0]   mem [32];
    bit          loaded;

    cp0_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_rd(req_rd),
        .req_sel(req_sel), .req_wdata(req_wdata), .req_rt(req_rt),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_rt(resp_rt),
        .exc_req(exc_req), .exc_epc(exc_epc), .exc_code(exc_code),
        .exc_bd(exc_bd), .exc_done(exc_done),
        .cp0_we(cp0_we), .cp0_re(cp0_re), .cp0_rd(cp0_rd),
        .cp0_sel(cp0_sel), .cp0_din(cp0_din), .cp0_dout(cp0_dout)
    );

    always #5 clk = ~clk;

    // Cycle counter: value seen between negedge and next posedge names the cycle
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: write on edge, read data one cycle after cp0_re
    always @(posedge clk) begin
        if (!loaded) begin
            mem[9]  <= 32'h1234_5678;
            mem[12] <= 32'h0000_FF01;
            loaded  <= 1'b1;
        end else begin
            if (cp0_we) mem[cp0_rd] <= cp0_din;
            if (cp0_re) cp0_dout <= mem[cp0_rd];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push(input int kind, input logic [4:0] rd, input logic [2:0] sel,
                        input logic [31:0] data, input int cy);
        ev_t e;
        e.kind = kind; e.rd = rd; e.sel = sel; e.data = data; e.cyc = cy;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [4:0] rd, input logic [2:0] sel,
                             input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            ntotal++;
            $display("FAIL unexpected_event: got kind %0d rd %0d data %h at cycle %0d, want none",
                     kind, rd, data, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind",  32'(kind), 32'(e.kind));
            chk("ev_rd_rt", 32'(rd), 32'(e.rd));
            chk("ev_sel",   32'(sel), 32'(e.sel));
            chk("ev_data",  data, e.data);
            chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_resp"},  {26'd0, resp_valid, resp_rt}, 0);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_strb"},  {29'd0, exc_done, cp0_we, cp0_re}, 0);
        chk({tag, "_addr"},  32'({cp0_rd, cp0_sel}), 0);
        chk({tag, "_din"},   cp0_din, 0);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (exc_done) seen = 1'b1;
        end
        if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor: every presented strobe/response/done pops the next expected event
    initial forever begin
        @(negedge clk); #2;
        chk("strobe_excl", 32'(cp0_we & cp0_re), 0);
        if (!cp0_we && !cp0_re) begin
            chk("idle_addr", 32'({cp0_rd, cp0_sel}), 0);
            chk("idle_din", cp0_din, 0);
        end else begin
            expect_ev(cp0_we ? K_WR : K_RD, cp0_rd, cp0_sel, cp0_we ? cp0_din : 32'd0);
        end
        if (resp_valid) expect_ev(K_RESP, resp_rt, 3'd0, resp_rdata);
        if (exc_done)   expect_ev(K_DONE, 5'd0, 3'd0, 32'd0);
    end

    initial begin
        rst = 1'b1; req_valid = 0; req_write = 0; req_rd = 0; req_sel = 0;
        req_wdata = 0; req_rt = 0; exc_req = 0; exc_epc = 0; exc_code = 0; exc_bd = 0;
        @(negedge clk); #1;
        check_all_zero("por");
        @(negedge clk);
        @(negedge clk); rst = 1'b0;

        // Reset asserted mid-cycle while an MFC0 is being offered
        @(negedge clk);
        req_valid = 1; req_write = 0; req_rd = 5'd9; req_rt = 5'd7;
        #1 rst = 1'b1;
        #2 check_all_zero("rst_mid");
        req_valid = 0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 1);

        // MTC0 writes: strobe in the same cycle, no response
        @(negedge clk); c = cyc;
        req_valid = 1; req_write = 1; req_rd = 5'd11; req_sel = 3'd0; req_wdata = 32'hDEAD_BEEF;
        #1 chk("mtc0_ready", 32'(req_ready), 1);
        push(K_WR, 5'd11, 3'd0, 32'hDEAD_BEEF, c);
        @(negedge clk); c = cyc;
        req_rd = 5'd16; req_sel = 3'd3; req_wdata = 32'h0000_00A5;
        #1 chk("mtc0b_ready", 32'(req_ready), 1);
        push(K_WR, 5'd16, 3'd3, 32'h0000_00A5, c);
        @(negedge clk); req_valid = 0; req_write = 0; req_sel = 0;
        repeat (2) @(negedge clk);

        // Back-to-back MFC0: accepted every second cycle
        @(negedge clk); c = cyc;
        req_valid = 1; req_write = 0; req_rd = 5'd9; req_rt = 5'd7;
        #1 chk("mfc0_ready", 32'(req_ready), 1);
        push(K_RD, 5'd9, 3'd0, 32'd0, c);
        push(K_RESP, 5'd7, 3'd0, 32'h1234_5678, c + 1);
        @(negedge clk);
        req_rd = 5'd12; req_rt = 5'd3;
        #1 chk("mfc0_wait_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1 chk("mfc0_2nd_ready", 32'(req_ready), 1);
        push(K_RD, 5'd12, 3'd0, 32'd0, c + 2);
        push(K_RESP, 5'd3, 3'd0, 32'h0000_FF01, c + 3);
        @(negedge clk); req_valid = 0;
        repeat (2) @(negedge clk);

        // Exception entry: EPC, Cause, Status read, Status|EXL write
        @(negedge clk); c = cyc;
        exc_req = 1; exc_epc = 32'hBFC0_0100; exc_code = 5'd8; exc_bd = 1;
        #1 chk("exc_ready", 32'(req_ready), 0);
        push(K_WR, 5'd14, 3'd0, 32'hBFC0_0100, c + 1);
        push(K_WR, 5'd13, 3'd0, 32'h8000_0020, c + 2);
        push(K_RD, 5'd12, 3'd0, 32'd0, c + 3);
        push(K_WR, 5'd12, 3'd0, 32'h0000_FF03, c + 4);
        push(K_DONE, 5'd0, 3'd0, 32'd0, c + 4);
        wait_done("exc1");
        exc_req = 0;
        repeat (2) @(negedge clk);

        // Collision: exception and MFC0 offered together
        @(negedge clk); c = cyc;
        exc_req = 1; exc_epc = 32'h8000_0180; exc_code = 5'd10; exc_bd = 0;
        req_valid = 1; req_write = 0; req_rd = 5'd9; req_rt = 5'd4;
        #1 chk("coll_ready", 32'(req_ready), 0);
        push(K_WR, 5'd14, 3'd0, 32'h8000_0180, c + 1);
        push(K_WR, 5'd13, 3'd0, 32'h0000_0028, c + 2);
        push(K_RD, 5'd12, 3'd0, 32'd0, c + 3);
        push(K_WR, 5'd12, 3'd0, 32'h0000_FF03, c + 4);
        push(K_DONE, 5'd0, 3'd0, 32'd0, c + 4);
        wait_done("coll");
        exc_req = 0;
        @(negedge clk);
        #1 chk("coll_mfc0_ready", 32'(req_ready), 1);
        push(K_RD, 5'd9, 3'd0, 32'd0, c + 5);
        push(K_RESP, 5'd4, 3'd0, 32'h1234_5678, c + 6);
        @(negedge clk); req_valid = 0;
        repeat (2) @(negedge clk);

        // Exception raised while a read response is pending
        @(negedge clk); c = cyc;
        req_valid = 1; req_write = 0; req_rd = 5'd9; req_rt = 5'd2;
        #1 chk("rdw_ready", 32'(req_ready), 1);
        push(K_RD, 5'd9, 3'd0, 32'd0, c);
        push(K_RESP, 5'd2, 3'd0, 32'h1234_5678, c + 1);
        @(negedge clk);
        req_valid = 0;
        exc_req = 1; exc_epc = 32'h0000_0040; exc_code = 5'd4; exc_bd = 1;
        push(K_WR, 5'd14, 3'd0, 32'h0000_0040, c + 3);
        push(K_WR, 5'd13, 3'd0, 32'h8000_0010, c + 4);
        push(K_RD, 5'd12, 3'd0, 32'd0, c + 5);
        push(K_WR, 5'd12, 3'd0, 32'h0000_FF03, c + 6);
        push(K_DONE, 5'd0, 3'd0, 32'd0, c + 6);
        wait_done("rdw");
        exc_req = 0;
        repeat (2) @(negedge clk);

        // Reset during EX_CAUSE: EPC write sticks, nothing further happens
        @(negedge clk); c = cyc;
        exc_req = 1; exc_epc = 32'h0000_1234; exc_code = 5'd3; exc_bd = 0;
        push(K_WR, 5'd14, 3'd0, 32'h0000_1234, c + 1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1; exc_req = 0;
        #1 check_all_zero("rst_cause");
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("epc_kept", mem[14], 32'h0000_1234);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
